mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares the single memory bus port between icache line-fill requests and dcache line requests (read or write-back).
- Sits between the two caches and the bus interface unit. Handles one outstanding transaction at a time and returns each response to the requester that owns it.
- Gives the icache its fill data (mem_data/mem_vld/mem_addr) in the same cycle the bus returns it.

Parameters:
- ADDR_W, 15, byte address width shared with the caches
- LINE_W, 256, cache line width in bits
- TIMEOUT, 64, WAIT-state cycles allowed before abort; minimum 2
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ic_req_vld  in  1  icache miss request
- ic_req_addr  in  ADDR_W  icache miss address
- ic_req_rd  out  1  icache request accepted (1-cycle pulse)
- ic_mem_vld  out  1  fill data valid to icache
- ic_mem_data  out  LINE_W  fill line to icache
- ic_mem_addr  out  ADDR_W  line-aligned fill address, {addr[14:5],5'b0}
- dc_req_vld  in  1  dcache request
- dc_req_addr  in  ADDR_W  dcache request address
- dc_req_wr  in  1  1 = write-back, 0 = read
- dc_wr_data  in  LINE_W  write-back line
- dc_req_rd  out  1  dcache request accepted (1-cycle pulse)
- dc_rsp_vld  out  1  dcache response (read data or write ack)
- dc_rsp_data  out  LINE_W  read line to dcache (zero for write ack)
- bus_req_vld  out  1  request to bus
- bus_req_addr  out  ADDR_W  line-aligned bus address
- bus_req_wr  out  1  write flag
- bus_wr_data  out  LINE_W  write data
- bus_req_rd  in  1  bus accepted request
- bus_rsp_vld  in  1  bus response valid
- bus_rsp_data  in  LINE_W  bus response line
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state = IDLE; last_grant = DC; counter = 0; err = 0; all latched fields = 0. Every vld/rd/busy output = 0 and every data output = 0 while rst is high. Reset mid-transaction drops the transaction; no response is generated.
- States: IDLE (0), ISSUE (1), WAIT (2).
- IDLE:
  - Arbitration is combinational. A single requester wins alone.
  - If both request, the winner is the requester that is not last_grant (round-robin). After reset the icache wins the first tie.
  - In the same cycle, the arbiter pulses the winner's *_req_rd, latches owner/addr/wr/data, updates last_grant, and moves to ISSUE.
  - The icache transaction type is always read.
- ISSUE:
  - bus_req_vld = 1 with the latched fields; bus_req_addr is line-aligned.
  - The latched fields hold until bus_req_rd = 1, then the state moves to WAIT with counter = 0.
  - There is no timeout in ISSUE.
- WAIT:
  - The counter increments each cycle.
  - On bus_rsp_vld = 1 the response is routed combinationally in the same cycle, then the state returns to IDLE:
    - owner IC: ic_mem_vld = 1, ic_mem_data = bus_rsp_data, ic_mem_addr = latched aligned address.
    - owner DC: dc_rsp_vld = 1, dc_rsp_data = bus_rsp_data for a read, 0 for a write.
  - If counter reaches TIMEOUT-1 without a response, err is set to 1, the state returns to IDLE, and no response is issued. err clears only on reset.
  - If bus_rsp_vld arrives in the same cycle the counter hits TIMEOUT-1, the response wins and err is not set.
- bus_rsp_vld outside WAIT is ignored.
- A new request is never accepted in the response cycle. The earliest next acceptance is the following cycle (IDLE).
- Minimum latency: accept at cycle 0, bus_req_vld at cycle 1, response no earlier than cycle 2.
- A requester must hold vld/addr/data until its *_req_rd pulse. Inputs that change before acceptance are sampled only at acceptance.
- ic_mem_data, ic_mem_addr and dc_rsp_data are 0 whenever their vld is 0.
- busy = 1 in ISSUE and WAIT.

Test Plan:
- Single icache read: ic_req_vld=1, addr=0x1234. Required: ic_req_rd pulse at cycle 0; bus_req_vld at cycle 1 with addr 0x1220, wr=0. With bus_req_rd at cycle 1 and bus_rsp at cycle 4 (data=0xAA..AA): ic_mem_vld=1, ic_mem_addr=0x1220 and the data all in cycle 4; busy=0 from cycle 5.
- Simultaneous requests after reset, repeated three times: grants must be IC, DC, IC. Each response must go only to its owner; the opposite vld stays 0.
- dcache write-back, addr=0x0040, data=0x5555..: bus_req_wr=1 and bus_wr_data=0x5555.. held across a 3-cycle bus_req_rd stall. On ack, dc_rsp_vld=1 with dc_rsp_data=0 and ic_mem_vld=0.
- Timeout with TIMEOUT=4 and no bus_rsp_vld: err=1 after the 4th WAIT cycle and state=IDLE. A subsequent request is still serviced and err stays 1.
- Boundary and reset:
  - bus_rsp_vld in the same cycle as TIMEOUT-1 is delivered and err=0.
  - bus_rsp_vld in IDLE produces no output.
  - rst asserted during WAIT clears all outputs immediately; a late bus_rsp_vld after reset produces no response.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one memory bus port between icache line fills and dcache line
// reads / write-backs. One transaction is in flight at a time. Each response
// is routed combinationally to the requester that owns the transaction.
// A WAIT phase that runs too long is aborted and flagged in the sticky err bit.

module mem_req_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic              ic_req_vld,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_rd,
  output logic              ic_mem_vld,
  output logic [LINE_W-1:0] ic_mem_data,
  output logic [ADDR_W-1:0] ic_mem_addr,
  // dcache side
  input  logic              dc_req_vld,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_wr,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_req_rd,
  output logic              dc_rsp_vld,
  output logic [LINE_W-1:0] dc_rsp_data,
  // bus interface unit side
  output logic              bus_req_vld,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_wr,
  output logic [LINE_W-1:0] bus_wr_data,
  input  logic              bus_req_rd,
  input  logic              bus_rsp_vld,
  input  logic [LINE_W-1:0] bus_rsp_data,
  // status
  output logic              busy,
  output logic              err
);

  // Byte-offset bits inside one cache line; cleared to line-align addresses.
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_W / 8 - 1);
  // Counter value of the last WAIT cycle before the transaction is abandoned.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_ic_q, last_ic_d;    // 1: icache got the last grant
  logic               owner_ic_q, owner_ic_d;  // 1: in-flight txn belongs to icache
  logic [ADDR_W-1:0]  addr_q, addr_d;          // line-aligned address
  logic               wr_q, wr_d;
  logic [LINE_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               grant_ic_s;
  logic               grant_dc_s;
  logic               rsp_take_s;              // response accepted this cycle

  // Clear the byte-offset bits of an address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    line_align = a & ~OFS_MASK;
  endfunction

  // Round-robin arbitration in IDLE: a lone requester wins, a tie goes to
  // whichever side was not granted last.
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (ic_req_vld && (!dc_req_vld || !last_ic_q)) begin
        grant_ic_s = 1'b1;
      end else if (dc_req_vld) begin
        grant_dc_s = 1'b1;
      end else begin
        grant_ic_s = 1'b0;
        grant_dc_s = 1'b0;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // A bus response only counts while waiting for one.
  always_comb begin
    rsp_take_s = 1'b0;
    if (state_q == WAIT) begin
      rsp_take_s = bus_rsp_vld;
    end else begin
      rsp_take_s = 1'b0;
    end
  end

  // Next-state logic: latch the winner, hand it to the bus, wait for the
  // response or abandon it after TIMEOUT WAIT cycles.
  always_comb begin
    state_d    = state_q;
    last_ic_d  = last_ic_q;
    owner_ic_d = owner_ic_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (grant_ic_s) begin
          owner_ic_d = 1'b1;
          addr_d     = line_align(ic_req_addr);
          wr_d       = 1'b0;
          data_d     = '0;
          last_ic_d  = 1'b1;
          state_d    = ISSUE;
        end else if (grant_dc_s) begin
          owner_ic_d = 1'b0;
          addr_d     = line_align(dc_req_addr);
          wr_d       = dc_req_wr;
          data_d     = dc_wr_data;
          last_ic_d  = 1'b0;
          state_d    = ISSUE;
        end else begin
          state_d    = IDLE;
        end
      end
      ISSUE: begin
        if (bus_req_rd) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (rsp_take_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // The response wins a tie with the last WAIT cycle, so the abort
          // is only taken when no response is present.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: acceptance pulses, bus request fields and response routing.
  // Every data output is forced to zero whenever its valid is low.
  always_comb begin
    ic_req_rd    = grant_ic_s;
    dc_req_rd    = grant_dc_s;
    ic_mem_vld   = 1'b0;
    ic_mem_data  = '0;
    ic_mem_addr  = '0;
    dc_rsp_vld   = 1'b0;
    dc_rsp_data  = '0;
    bus_req_vld  = 1'b0;
    bus_req_addr = '0;
    bus_req_wr   = 1'b0;
    bus_wr_data  = '0;
    if (state_q == ISSUE) begin
      bus_req_vld  = 1'b1;
      bus_req_addr = addr_q;
      bus_req_wr   = wr_q;
      bus_wr_data  = data_q;
    end else begin
      bus_req_vld  = 1'b0;
    end
    if (rsp_take_s && owner_ic_q) begin
      ic_mem_vld  = 1'b1;
      ic_mem_data = bus_rsp_data;
      ic_mem_addr = addr_q;
    end else if (rsp_take_s) begin
      dc_rsp_vld  = 1'b1;
      // A write-back is acknowledged with an all-zero line.
      dc_rsp_data = wr_q ? '0 : bus_rsp_data;
    end else begin
      ic_mem_vld  = 1'b0;
      dc_rsp_vld  = 1'b0;
    end
  end

  // Status outputs follow the state register and the sticky error flop.
  always_comb begin
    busy = (state_q != IDLE);
    err  = err_q;
  end

  // State and latched-transaction registers; reset drops any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_ic_q  <= 1'b0;
      owner_ic_q <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ic_q  <= last_ic_d;
      owner_ic_q <= owner_ic_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level reference model.

module tb_mem_req_arbiter;

  localparam int ADDR_W  = 15;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ic_req_vld = 1'b0;
  logic [ADDR_W-1:0] ic_req_addr = '0;
  logic              ic_req_rd;
  logic              ic_mem_vld;
  logic [LINE_W-1:0] ic_mem_data;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic              dc_req_vld = 1'b0;
  logic [ADDR_W-1:0] dc_req_addr = '0;
  logic              dc_req_wr = 1'b0;
  logic [LINE_W-1:0] dc_wr_data = '0;
  logic              dc_req_rd;
  logic              dc_rsp_vld;
  logic [LINE_W-1:0] dc_rsp_data;
  logic              bus_req_vld;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_req_wr;
  logic [LINE_W-1:0] bus_wr_data;
  logic              bus_req_rd = 1'b0;
  logic              bus_rsp_vld = 1'b0;
  logic [LINE_W-1:0] bus_rsp_data = '0;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  mem_req_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ic_req_vld  (ic_req_vld),
    .ic_req_addr (ic_req_addr),
    .ic_req_rd   (ic_req_rd),
    .ic_mem_vld  (ic_mem_vld),
    .ic_mem_data (ic_mem_data),
    .ic_mem_addr (ic_mem_addr),
    .dc_req_vld  (dc_req_vld),
    .dc_req_addr (dc_req_addr),
    .dc_req_wr   (dc_req_wr),
    .dc_wr_data  (dc_wr_data),
    .dc_req_rd   (dc_req_rd),
    .dc_rsp_vld  (dc_rsp_vld),
    .dc_rsp_data (dc_rsp_data),
    .bus_req_vld (bus_req_vld),
    .bus_req_addr(bus_req_addr),
    .bus_req_wr  (bus_req_wr),
    .bus_wr_data (bus_wr_data),
    .bus_req_rd  (bus_req_rd),
    .bus_rsp_vld (bus_rsp_vld),
    .bus_rsp_data(bus_rsp_data),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & 15'h7FE0;
  endfunction

  // ---------------- reference model (one transaction record) ----------------
  logic              m_txn = 1'b0;      // a transaction is owned by the arbiter
  logic              m_issued = 1'b0;   // bus has accepted it
  int                m_waited = 0;      // response-less WAIT cycles already spent
  logic              m_own_ic = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_wr = 1'b0;
  logic [LINE_W-1:0] m_data = '0;
  logic              m_ic_last = 1'b0;
  logic              m_err = 1'b0;
  logic              m_ic_acc = 1'b0;
  logic              m_dc_acc = 1'b0;

  logic              e_ic_rd, e_dc_rd, e_ic_vld, e_dc_vld, e_bus_vld, e_bus_wr, e_busy, e_err;
  logic [LINE_W-1:0] e_ic_data, e_dc_data, e_bus_data;
  logic [ADDR_W-1:0] e_ic_addr, e_bus_addr;

  // Compare process: predict this cycle's outputs, compare, then advance.
  always @(negedge clk) begin
    e_ic_rd = 1'b0; e_dc_rd = 1'b0; e_ic_vld = 1'b0; e_dc_vld = 1'b0;
    e_bus_vld = 1'b0; e_bus_wr = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_ic_data = '0; e_dc_data = '0; e_bus_data = '0; e_ic_addr = '0; e_bus_addr = '0;
    m_ic_acc = 1'b0; m_dc_acc = 1'b0;
    if (rst) begin
      m_txn = 1'b0; m_ic_last = 1'b0; m_err = 1'b0;
    end else begin
      e_err  = m_err;
      e_busy = m_txn;
      if (!m_txn) begin
        if (ic_req_vld && (!dc_req_vld || !m_ic_last)) begin
          e_ic_rd = 1'b1; m_ic_acc = 1'b1;
          m_txn = 1'b1; m_issued = 1'b0; m_own_ic = 1'b1;
          m_addr = align(ic_req_addr); m_wr = 1'b0; m_data = '0; m_ic_last = 1'b1;
        end else if (dc_req_vld) begin
          e_dc_rd = 1'b1; m_dc_acc = 1'b1;
          m_txn = 1'b1; m_issued = 1'b0; m_own_ic = 1'b0;
          m_addr = align(dc_req_addr); m_wr = dc_req_wr; m_data = dc_wr_data; m_ic_last = 1'b0;
        end
      end else if (!m_issued) begin
        e_bus_vld = 1'b1; e_bus_addr = m_addr; e_bus_wr = m_wr; e_bus_data = m_data;
        if (bus_req_rd) begin
          m_issued = 1'b1; m_waited = 0;
        end
      end else begin
        if (bus_rsp_vld) begin
          if (m_own_ic) begin
            e_ic_vld = 1'b1; e_ic_data = bus_rsp_data; e_ic_addr = m_addr;
          end else begin
            e_dc_vld = 1'b1; e_dc_data = m_wr ? '0 : bus_rsp_data;
          end
          m_txn = 1'b0;
        end else if (m_waited + 1 == TIMEOUT) begin
          m_err = 1'b1; m_txn = 1'b0;
        end else begin
          m_waited++;
        end
      end
    end
    chk("ic_req_rd", ic_req_rd, e_ic_rd);
    chk("dc_req_rd", dc_req_rd, e_dc_rd);
    chk("ic_mem_vld", ic_mem_vld, e_ic_vld);
    chk("ic_mem_data", ic_mem_data, e_ic_data);
    chk("ic_mem_addr", ic_mem_addr, e_ic_addr);
    chk("dc_rsp_vld", dc_rsp_vld, e_dc_vld);
    chk("dc_rsp_data", dc_rsp_data, e_dc_data);
    chk("bus_req_vld", bus_req_vld, e_bus_vld);
    chk("bus_req_addr", bus_req_addr, e_bus_addr);
    chk("bus_req_wr", bus_req_wr, e_bus_wr);
    chk("bus_wr_data", bus_wr_data, e_bus_data);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_vld = 1'b0; ic_req_addr = '0;
    dc_req_vld = 1'b0; dc_req_addr = '0; dc_req_wr = 1'b0; dc_wr_data = '0;
    bus_req_rd = 1'b0; bus_rsp_vld = 1'b0; bus_rsp_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Accept an icache read and let the bus take it at once; returns at the
  // start of the first WAIT cycle.
  task automatic ic_issue(input logic [ADDR_W-1:0] a);
    ic_req_vld = 1'b1; ic_req_addr = a;
    @(negedge clk); chk("issue_ic_rd", ic_req_rd, 1'b1);
    cyc();
    ic_req_vld = 1'b0; bus_req_rd = 1'b1;
    @(negedge clk); chk("issue_bus_vld", bus_req_vld, 1'b1);
    cyc();
    bus_req_rd = 1'b0;
  endtask

  logic              wic;
  logic [LINE_W-1:0] line_v;
  logic [ADDR_W-1:0] ic_a, dc_a;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    do_reset();

    // Single icache read (cycle 0 = acceptance)
    ic_req_vld = 1'b1; ic_req_addr = 15'h1234;
    @(negedge clk); chk("t1_ic_rd_c0", ic_req_rd, 1'b1); chk("t1_busy_c0", busy, 1'b0);
    cyc();
    ic_req_vld = 1'b0; bus_req_rd = 1'b1;
    @(negedge clk);
    chk("t1_bus_vld_c1", bus_req_vld, 1'b1);
    chk("t1_bus_addr_c1", bus_req_addr, 15'h1220);
    chk("t1_bus_wr_c1", bus_req_wr, 1'b0);
    cyc(); bus_req_rd = 1'b0;
    @(negedge clk); chk("t1_busy_c2", busy, 1'b1);
    cyc();
    cyc(); bus_rsp_vld = 1'b1; bus_rsp_data = {32{8'hAA}};
    @(negedge clk);
    chk("t1_ic_vld_c4", ic_mem_vld, 1'b1);
    chk("t1_ic_addr_c4", ic_mem_addr, 15'h1220);
    chk("t1_ic_data_c4", ic_mem_data, {32{8'hAA}});
    chk("t1_dc_vld_c4", dc_rsp_vld, 1'b0);
    cyc(); bus_rsp_vld = 1'b0; bus_rsp_data = '0;
    @(negedge clk); chk("t1_busy_c5", busy, 1'b0);

    // Simultaneous requests after reset: grants IC, DC, IC
    do_reset();
    ic_a = 15'h0A47; dc_a = 15'h3C19;
    ic_req_addr = ic_a; dc_req_addr = dc_a; dc_req_wr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wic = (r != 1);
      ic_req_vld = 1'b1; dc_req_vld = 1'b1;
      @(negedge clk);
      chk("tie_ic_rd", ic_req_rd, wic);
      chk("tie_dc_rd", dc_req_rd, !wic);
      cyc();
      if (wic) ic_req_vld = 1'b0;
      else dc_req_vld = 1'b0;
      bus_req_rd = 1'b1;
      @(negedge clk); chk("tie_bus_addr", bus_req_addr, wic ? 15'h0A40 : 15'h3C00);
      cyc();
      bus_req_rd = 1'b0; bus_rsp_vld = 1'b1; line_v = rand_line(); bus_rsp_data = line_v;
      @(negedge clk);
      chk("tie_ic_vld", ic_mem_vld, wic);
      chk("tie_dc_vld", dc_rsp_vld, !wic);
      chk("tie_owner_data", wic ? ic_mem_data : dc_rsp_data, line_v);
      cyc();
      bus_rsp_vld = 1'b0;
    end
    do_reset();

    // dcache write-back with a 3-cycle bus stall
    dc_req_vld = 1'b1; dc_req_addr = 15'h0040; dc_req_wr = 1'b1; dc_wr_data = {64{4'h5}};
    @(negedge clk); chk("wb_dc_rd", dc_req_rd, 1'b1);
    cyc();
    dc_req_vld = 1'b0; dc_req_wr = 1'b0; dc_wr_data = '0;
    for (int s = 0; s < 4; s++) begin
      bus_req_rd = (s == 3);
      @(negedge clk);
      chk("wb_bus_vld", bus_req_vld, 1'b1);
      chk("wb_bus_wr", bus_req_wr, 1'b1);
      chk("wb_bus_addr", bus_req_addr, 15'h0040);
      chk("wb_bus_data", bus_wr_data, {64{4'h5}});
      cyc();
    end
    bus_req_rd = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = {32{8'hC3}};
    @(negedge clk);
    chk("wb_dc_vld", dc_rsp_vld, 1'b1);
    chk("wb_dc_data", dc_rsp_data, '0);
    chk("wb_ic_vld", ic_mem_vld, 1'b0);
    cyc(); bus_rsp_vld = 1'b0;

    // Response in the last allowed WAIT cycle wins over the timeout
    ic_issue(15'h0300);
    cyc(); cyc(); cyc();
    bus_rsp_vld = 1'b1; bus_rsp_data = {32{8'h3C}};
    @(negedge clk);
    chk("edge_ic_vld", ic_mem_vld, 1'b1);
    chk("edge_ic_data", ic_mem_data, {32{8'h3C}});
    cyc(); bus_rsp_vld = 1'b0;
    @(negedge clk); chk("edge_err", err, 1'b0); chk("edge_busy", busy, 1'b0);

    // bus_rsp_vld while IDLE is ignored
    cyc(); bus_rsp_vld = 1'b1; bus_rsp_data = {32{8'h77}};
    @(negedge clk);
    chk("idle_ic_vld", ic_mem_vld, 1'b0);
    chk("idle_dc_vld", dc_rsp_vld, 1'b0);
    chk("idle_ic_data", ic_mem_data, '0);
    cyc(); bus_rsp_vld = 1'b0;

    // Timeout: four WAIT cycles without response
    ic_issue(15'h0100);
    cyc(); cyc(); cyc();
    @(negedge clk); chk("to_busy_w4", busy, 1'b1); chk("to_err_w4", err, 1'b0);
    cyc();
    ic_req_vld = 1'b1; ic_req_addr = 15'h0215;
    @(negedge clk);
    chk("to_err_set", err, 1'b1);
    chk("to_busy_idle", busy, 1'b0);
    chk("to_next_rd", ic_req_rd, 1'b1);
    cyc(); ic_req_vld = 1'b0; bus_req_rd = 1'b1;
    cyc(); bus_req_rd = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = {32{8'h5A}};
    @(negedge clk);
    chk("to_next_vld", ic_mem_vld, 1'b1);
    chk("to_next_addr", ic_mem_addr, 15'h0200);
    chk("to_err_sticky", err, 1'b1);
    cyc(); bus_rsp_vld = 1'b0;

    // Reset in the middle of WAIT
    ic_issue(15'h0700);
    cyc();
    rst = 1'b1; ic_req_vld = 1'b1;
    @(negedge clk);
    chk("mid_rst_ic_rd", ic_req_rd, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_bus_vld", bus_req_vld, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    cyc();
    rst = 1'b0; ic_req_vld = 1'b0; bus_rsp_vld = 1'b1; bus_rsp_data = {32{8'h99}};
    @(negedge clk);
    chk("late_rsp_ic_vld", ic_mem_vld, 1'b0);
    chk("late_rsp_ic_data", ic_mem_data, '0);
    chk("late_rsp_dc_vld", dc_rsp_vld, 1'b0);
    cyc(); bus_rsp_vld = 1'b0;

    // Randomized traffic; requesters hold until their acceptance pulse
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (!ic_req_vld || m_ic_acc) begin
        ic_req_vld  = ($urandom_range(0, 2) == 0);
        ic_req_addr = ADDR_W'($urandom());
      end
      if (!dc_req_vld || m_dc_acc) begin
        dc_req_vld  = ($urandom_range(0, 2) == 0);
        dc_req_addr = ADDR_W'($urandom());
        dc_req_wr   = $urandom_range(0, 1) == 1;
        dc_wr_data  = rand_line();
      end
      bus_req_rd   = $urandom_range(0, 1) == 1;
      bus_rsp_vld  = ($urandom_range(0, 4) < 2);
      bus_rsp_data = rand_line();
      cyc();
    end
    rst = 1'b0;
    clear_inputs();
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
